// File: rtl/grid_commit_scheduler.sv
// Player write arbiter and FIFO for the 8x13 object grid.
// Buffered writes are committed only inside the vsync window.
module grid_commit_scheduler #(
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_COMMITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic [3:0]            req_valid,
  input  logic [3:0][3:0]       req_x,
  input  logic [3:0][2:0]       req_y,
  input  logic [3:0][3:0]       req_obj,
  output logic [3:0]            req_ready,
  output logic [7:0][12:0][3:0] object_grid,
  output logic [4:0]            fifo_count,
  output logic                  commit_pulse,
  output logic                  oob_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_COMMITS + 1);

  typedef struct packed {
    logic [3:0] x;
    logic [2:0] y;
    logic [3:0] obj;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } state_t;

  entry_t                  r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [4:0]              r_count;
  logic [1:0]              r_ptr;
  logic                    r_vs_q;
  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_pops;
  logic [7:0][12:0][3:0]   r_grid;
  logic                    r_commit;
  logic                    r_oob;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_can_enq;
  logic                    w_limit;
  logic [3:0]              w_rot;
  logic [1:0]              w_off;
  logic [1:0]              w_sel;
  logic [3:0]              w_grant;
  entry_t                  w_in;
  entry_t                  w_head;

  assign w_empty = (r_count == 5'd0);
  assign w_full  = (r_count == 5'(FIFO_DEPTH));
  assign w_limit = (r_pops >= CW'(MAX_COMMITS));
  assign w_head  = r_mem[r_rd];

  assign w_pop = (r_state == S_DRAIN) && !vsync
              && !w_empty && !w_limit;

  // A full FIFO still accepts when a pop frees a slot this cycle.
  assign w_can_enq = !w_full || w_pop;

  assign w_rot = 4'({req_valid, req_valid} >> r_ptr);

  always_comb begin
    w_off = 2'd0;
    priority case (1'b1)
      w_rot[0]: w_off = 2'd0;
      w_rot[1]: w_off = 2'd1;
      w_rot[2]: w_off = 2'd2;
      w_rot[3]: w_off = 2'd3;
      default:  w_off = 2'd0;
    endcase
  end

  assign w_sel   = r_ptr + w_off;
  assign w_grant = (|w_rot && w_can_enq) ? (4'b0001 << w_sel) : 4'b0000;
  assign w_push  = |w_grant;

  assign req_ready = w_grant;

  assign w_in.x   = req_x[w_sel];
  assign w_in.y   = req_y[w_sel];
  assign w_in.obj = req_obj[w_sel];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_vs_q && !vsync) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (vsync || w_empty || w_limit) w_next = S_DONE;
      end
      S_DONE: begin
        if (vsync) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= w_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_ptr    <= '0;
      r_vs_q   <= 1'b0;
      r_state  <= S_IDLE;
      r_pops   <= '0;
      r_grid   <= '0;
      r_commit <= 1'b0;
      r_oob    <= 1'b0;
    end else begin
      r_vs_q   <= vsync;
      r_state  <= w_next;
      r_commit <= (r_state == S_DRAIN) && (w_next == S_DONE);
      r_oob    <= w_pop && (w_head.x > 4'd12);
      if (w_push) begin
        r_wr  <= r_wr + 1'b1;
        r_ptr <= w_sel + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (r_state != S_DRAIN) r_pops <= '0;
      else if (w_pop)         r_pops <= r_pops + 1'b1;
      if (w_pop && (w_head.x <= 4'd12))
        r_grid[w_head.y][w_head.x] <= w_head.obj;
    end
  end

  assign object_grid  = r_grid;
  assign fifo_count   = r_count;
  assign commit_pulse = r_commit;
  assign oob_error    = r_oob;

endmodule

// File: tb/tb_grid_commit_scheduler.sv
// Bench for grid_commit_scheduler: constant vectors, directed
// vsync-window sequences and random traffic against a queue model.
module tb_grid_commit_scheduler;

  localparam int DEPTH = 8;
  localparam int MAXC  = 4;
  localparam int GW    = 416;

  typedef logic [GW-1:0] wide_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  vsync;
  logic [3:0]            req_valid;
  logic [3:0][3:0]       req_x;
  logic [3:0][2:0]       req_y;
  logic [3:0][3:0]       req_obj;
  logic [3:0]            req_ready;
  logic [7:0][12:0][3:0] object_grid;
  logic [4:0]            fifo_count;
  logic                  commit_pulse;
  logic                  oob_error;

  always #5 clock = ~clock;

  grid_commit_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .MAX_COMMITS(MAXC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_obj     (req_obj),
    .req_ready   (req_ready),
    .object_grid (object_grid),
    .fifo_count  (fifo_count),
    .commit_pulse(commit_pulse),
    .oob_error   (oob_error)
  );

  // Reference model: a plain queue of pending writes, a grid array
  // and a window phase (0 waiting for vsync fall, 1 draining,
  // 2 window finished, waiting for vsync high).
  typedef struct {
    int x;
    int y;
    int obj;
  } ent_t;

  ent_t       m_q[$];
  int         m_grid[8][13];
  int         m_ptr;
  int         m_mode;
  int         m_pops;
  bit         m_prev_vs;
  bit         m_commit;
  bit         m_oob;
  bit         m_pop;
  int         m_win;
  logic [3:0] m_ready;

  int         n_tests = 0;
  int         n_fail = 0;
  int         n_commit = 0;
  int         n_oob = 0;
  logic [3:0] seen_ready;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    int         exp_count;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][12:0][3:0] grid_vec();
    logic [7:0][12:0][3:0] v;
    v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 13; c++)
        v[r][c] = 4'(m_grid[r][c]);
    return v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 13; c++)
        m_grid[r][c] = 0;
    m_ptr = 0;
    m_mode = 0;
    m_pops = 0;
    m_prev_vs = 1'b0;
    m_commit = 1'b0;
    m_oob = 1'b0;
  endtask

  task automatic model_comb();
    m_pop = (m_mode == 1) && !vsync && (m_q.size() > 0) && (m_pops < MAXC);
    m_ready = 4'b0000;
    m_win = -1;
    if (m_q.size() < DEPTH || m_pop)
      for (int k = 0; k < 4; k++)
        if (m_win < 0 && req_valid[(m_ptr + k) % 4])
          m_win = (m_ptr + k) % 4;
    if (m_win >= 0) m_ready[m_win] = 1'b1;
  endtask

  task automatic model_edge();
    ent_t e;
    if (reset) begin
      model_clear();
      return;
    end
    m_commit = 1'b0;
    m_oob = 1'b0;
    if (m_mode == 0) begin
      if (m_prev_vs && !vsync) begin
        m_mode = 1;
        m_pops = 0;
      end
    end else if (m_mode == 1) begin
      if (vsync || m_q.size() == 0 || m_pops == MAXC) begin
        m_commit = 1'b1;
        m_mode = 2;
      end else begin
        e = m_q.pop_front();
        m_pops++;
        if (e.x <= 12) m_grid[e.y][e.x] = e.obj;
        else m_oob = 1'b1;
      end
    end else begin
      if (vsync) m_mode = 0;
    end
    if (m_win >= 0) begin
      e.x = int'(req_x[m_win]);
      e.y = int'(req_y[m_win]);
      e.obj = int'(req_obj[m_win]);
      m_q.push_back(e);
      m_ptr = (m_win + 1) % 4;
    end
    m_prev_vs = vsync;
  endtask

  task automatic step();
    model_comb();
    @(negedge clock);
    seen_ready = req_ready;
    if (!reset) chk("ready", wide_t'(req_ready), wide_t'(m_ready));
    model_edge();
    @(posedge clock);
    #1;
    chk("count", wide_t'(fifo_count), wide_t'(m_q.size()));
    chk("commit", wide_t'(commit_pulse), wide_t'(m_commit));
    chk("oob", wide_t'(oob_error), wide_t'(m_oob));
    chk("grid", wide_t'(object_grid), wide_t'(grid_vec()));
    if (commit_pulse) n_commit++;
    if (oob_error) n_oob++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vsync = 1'b1;
    req_valid = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic req1(input int p, input int x, input int y, input int o);
    req_valid = 4'b0001 << p;
    req_x[p] = 4'(x);
    req_y[p] = 3'(y);
    req_obj[p] = 4'(o);
    step();
    req_valid = 4'b0000;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int c0;
  int o0;

  initial begin
    tbl[0] = '{4'b1111, 4'b0001, 1};
    tbl[1] = '{4'b1111, 4'b0010, 2};
    tbl[2] = '{4'b1111, 4'b0100, 3};
    tbl[3] = '{4'b1111, 4'b1000, 4};
    tbl[4] = '{4'b1010, 4'b0010, 5};
    tbl[5] = '{4'b1010, 4'b1000, 6};
    tbl[6] = '{4'b0001, 4'b0001, 7};
    tbl[7] = '{4'b0100, 4'b0100, 8};
    tbl[8] = '{4'b1111, 4'b0000, 8};
    tbl[9] = '{4'b1111, 4'b0000, 8};

    reset = 1'b1;
    vsync = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_obj = '0;
    model_clear();
    @(posedge clock);
    #1;

    // Single request from player 2, then a one-entry window.
    do_reset();
    chk("rst_count", wide_t'(fifo_count), wide_t'(0));
    chk("rst_grid", wide_t'(object_grid), wide_t'(0));
    chk("rst_commit", wide_t'(commit_pulse), wide_t'(0));
    req1(2, 3, 1, 5);
    chk("p2_ready", wide_t'(seen_ready), wide_t'(4'b0100));
    steps(100);
    chk("p2_count", wide_t'(fifo_count), wide_t'(1));
    chk("p2_grid0", wide_t'(object_grid), wide_t'(0));
    c0 = n_commit;
    vsync = 1'b0;
    step();
    step();
    chk("cell13", wide_t'(object_grid[1][3]), wide_t'(5));
    chk("no_commit_yet", wide_t'(commit_pulse), wide_t'(0));
    step();
    chk("commit_after", wide_t'(commit_pulse), wide_t'(1));
    chk("p2_empty", wide_t'(fifo_count), wide_t'(0));
    steps(3);
    chk("one_commit", wide_t'(n_commit - c0), wide_t'(1));

    // Rotation and full FIFO from the constant table.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].valid;
      for (int p = 0; p < 4; p++) begin
        req_x[p] = 4'(p + i);
        req_y[p] = 3'(p);
        req_obj[p] = 4'(i + 1);
      end
      step();
      chk($sformatf("tbl%0d_ready", i), wide_t'(seen_ready),
          wide_t'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_count", i), wide_t'(fifo_count),
          wide_t'(tbl[i].exp_count));
    end
    req_valid = 4'b0000;

    // Eight queued, window limited to four pops.
    c0 = n_commit;
    vsync = 1'b0;
    steps(10);
    chk("limit_count", wide_t'(fifo_count), wide_t'(4));
    chk("limit_commit", wide_t'(n_commit - c0), wide_t'(1));
    vsync = 1'b1;
    steps(3);
    vsync = 1'b0;
    steps(10);
    chk("second_window", wide_t'(fifo_count), wide_t'(0));
    chk("two_commits", wide_t'(n_commit - c0), wide_t'(2));

    // Out-of-range column is dropped with an error pulse.
    do_reset();
    req1(0, 14, 0, 2);
    req1(0, 0, 0, 7);
    o0 = n_oob;
    vsync = 1'b0;
    steps(6);
    chk("oob_pulses", wide_t'(n_oob - o0), wide_t'(1));
    chk("cell00", wide_t'(object_grid[0][0]), wide_t'(7));

    // Same cell written twice in one window: last write wins.
    do_reset();
    req1(1, 5, 2, 1);
    req1(2, 5, 2, 9);
    vsync = 1'b0;
    steps(6);
    chk("last_wins", wide_t'(object_grid[2][5]), wide_t'(9));

    // Reset on the second drain cycle.
    do_reset();
    req1(0, 1, 1, 3);
    req1(1, 2, 2, 4);
    req1(2, 3, 3, 5);
    vsync = 1'b0;
    step();
    step();
    chk("pre_rst_cell", wide_t'(object_grid[1][1]), wide_t'(3));
    c0 = n_commit;
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(4);
    chk("midrst_grid", wide_t'(object_grid), wide_t'(0));
    chk("midrst_count", wide_t'(fifo_count), wide_t'(0));
    chk("midrst_commit", wide_t'(n_commit - c0), wide_t'(0));

    // Random traffic with random vsync windows.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) begin
        req_x[p] = 4'($urandom_range(0, 15));
        req_y[p] = 3'($urandom_range(0, 7));
        req_obj[p] = 4'($urandom_range(0, 15));
      end
      if (vsync) begin
        if ($urandom_range(0, 14) == 0) vsync = 1'b0;
      end else begin
        if ($urandom_range(0, 5) == 0) vsync = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
